// File: rtl/key_byte_assembler.sv
// Packs a byte stream big-endian into a 32-bit key and presents it with a valid/ack handshake.
// Optional partial-key idle timeout: define KEY_BYTE_ASSEMBLER_TIMEOUT_EN.
module key_byte_assembler #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] key,
  output logic        key_valid,
  input  logic        key_ack,
  output logic [1:0]  byte_cnt,
  output logic        err_timeout
);

  typedef enum logic [0:0] {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [23:0] acc;
  logic        xfer;
  logic        complete;
  logic        expire;

  // in_ready decodes registered state only, so an ack never opens the input in the same cycle
  assign in_ready = (state_q == COLLECT);
  assign xfer     = in_valid && in_ready;
  assign complete = xfer && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (complete) state_d = HOLD;
      HOLD:    if (key_ack)  state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      byte_cnt  <= '0;
      key       <= '0;
      key_valid <= 1'b0;
    end else begin
      if (complete) begin
        key       <= {acc, in_byte};
        key_valid <= 1'b1;
        acc       <= '0;
        byte_cnt  <= '0;
      end else if (xfer) begin
        acc      <= {acc[15:0], in_byte};
        byte_cnt <= byte_cnt + 2'd1;
      end else if (expire) begin
        acc      <= '0;
        byte_cnt <= '0;
      end
      if ((state_q == HOLD) && key_ack) key_valid <= 1'b0;
    end
  end

`ifdef KEY_BYTE_ASSEMBLER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC) + 1;

  logic [IDLE_W-1:0] idle_cnt;

  // A transfer in the expiry cycle wins over the timeout
  assign expire = (state_q == COLLECT) && (byte_cnt != 2'd0) && !xfer &&
                  (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= expire;
      if ((state_q != COLLECT) || (byte_cnt == 2'd0) || xfer || expire)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
  // Constant 0; the term only keeps TIMEOUT_CYC referenced in this build
  assign err_timeout = 1'b0 && (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_key_byte_assembler.sv
// Bench for key_byte_assembler: vector table, hand-written reset/timeout sequences, random run vs queue model.
module tb_key_byte_assembler;

  localparam int TCYC = 8;
`ifdef KEY_BYTE_ASSEMBLER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] key;
  logic        key_valid;
  logic        key_ack;
  logic [1:0]  byte_cnt;
  logic        err_timeout;

  int checks = 0;
  int failures = 0;

  key_byte_assembler #(.TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .key_valid(key_valid), .key_ack(key_ack), .byte_cnt(byte_cnt),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: bytes of the partial key kept in a queue
  logic [7:0]  m_q[$];
  logic        m_hold;
  logic [31:0] m_key;
  logic        m_kv;
  logic        m_err;
  int          m_idle;

  task automatic model_reset();
    m_q.delete();
    m_hold = 1'b0; m_key = '0; m_kv = 1'b0; m_err = 1'b0; m_idle = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic a);
    m_err = 1'b0;
    if (!m_hold) begin
      if (v) begin
        m_q.push_back(b);
        m_idle = 0;
        if (m_q.size() == 4) begin
          m_key  = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_kv   = 1'b1;
          m_hold = 1'b1;
          m_q.delete();
        end
      end else if (TO_EN && m_q.size() != 0) begin
        if (m_idle == TCYC - 1) begin
          m_q.delete();
          m_err  = 1'b1;
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end
    end else if (a) begin
      m_kv   = 1'b0;
      m_hold = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".key"}, key, m_key);
    chk({tag, ".key_valid"}, 32'(key_valid), 32'(m_kv));
    chk({tag, ".byte_cnt"}, 32'(byte_cnt), 32'(m_q.size()));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_hold));
    chk({tag, ".err_timeout"}, 32'(err_timeout), 32'(m_err));
  endtask

  // Called at a negedge: apply inputs for one clock, return at the next negedge
  task automatic drive(input logic v, input logic [7:0] b, input logic a);
    in_valid = v; in_byte = b; key_ack = a;
    model_step(v, b, a);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_byte = '0; key_ack = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic        v;
    logic [7:0]  b;
    logic        a;
    logic [31:0] k;
    logic        kv;
    logic [1:0]  cnt;
    logic        rdy;
  } vec_t;

  vec_t tbl [0:12];

  initial begin
    tbl[0]  = '{1'b1, 8'h4C, 1'b0, 32'h00000000, 1'b0, 2'd1, 1'b1};
    tbl[1]  = '{1'b1, 8'h6F, 1'b0, 32'h00000000, 1'b0, 2'd2, 1'b1};
    tbl[2]  = '{1'b1, 8'h74, 1'b0, 32'h00000000, 1'b0, 2'd3, 1'b1};
    tbl[3]  = '{1'b1, 8'h52, 1'b0, 32'h4C6F7452, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 8'h4C, 1'b0, 32'h4C6F7452, 1'b1, 2'd0, 1'b0};
    tbl[5]  = '{1'b1, 8'h4C, 1'b0, 32'h4C6F7452, 1'b1, 2'd0, 1'b0};
    tbl[6]  = '{1'b1, 8'h4C, 1'b0, 32'h4C6F7452, 1'b1, 2'd0, 1'b0};
    tbl[7]  = '{1'b1, 8'h4C, 1'b1, 32'h4C6F7452, 1'b0, 2'd0, 1'b1};
    tbl[8]  = '{1'b1, 8'h4C, 1'b0, 32'h4C6F7452, 1'b0, 2'd1, 1'b1};
    tbl[9]  = '{1'b1, 8'h6F, 1'b0, 32'h4C6F7452, 1'b0, 2'd2, 1'b1};
    tbl[10] = '{1'b1, 8'h74, 1'b0, 32'h4C6F7452, 1'b0, 2'd3, 1'b1};
    tbl[11] = '{1'b1, 8'h53, 1'b0, 32'h4C6F7453, 1'b1, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 32'h4C6F7453, 1'b0, 2'd0, 1'b1};

    // Reset state, sampled while reset is asserted
    in_valid = 1'b0; in_byte = '0; key_ack = 1'b0; rst_n = 1'b0;
    model_reset();
    #3;
    chk("rst.key", key, 32'h0);
    chk("rst.key_valid", 32'(key_valid), 32'h0);
    chk("rst.byte_cnt", 32'(byte_cnt), 32'h0);
    chk("rst.in_ready", 32'(in_ready), 32'h1);
    chk("rst.err_timeout", 32'(err_timeout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].b, tbl[i].a);
      chk($sformatf("vec%0d.key", i), key, tbl[i].k);
      chk($sformatf("vec%0d.key_valid", i), 32'(key_valid), 32'(tbl[i].kv));
      chk($sformatf("vec%0d.byte_cnt", i), 32'(byte_cnt), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
    end

    // Asynchronous reset mid-key, between clock edges
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    chk("midkey.byte_cnt", 32'(byte_cnt), 32'h2);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async.key", key, 32'h0);
    chk("async.key_valid", 32'(key_valid), 32'h0);
    chk("async.byte_cnt", 32'(byte_cnt), 32'h0);
    chk("async.in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h00, 1'b0);
    chk("zero.key", key, 32'h0);
    chk("zero.key_valid", 32'(key_valid), 32'h1);
    chk("zero.in_ready", 32'(in_ready), 32'h0);
    drive(1'b0, 8'h00, 1'b1);
    chk("zero.ack", 32'(key_valid), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0));
      chk_model($sformatf("rnd%0d", i));
    end

`ifdef KEY_BYTE_ASSEMBLER_TIMEOUT_EN
    begin
      int pulses;
      do_reset();
      drive(1'b1, 8'h4C, 1'b0);
      pulses = 0;
      for (int i = 1; i <= 8; i++) begin
        drive(1'b0, 8'h00, 1'b0);
        if (err_timeout) pulses++;
        chk($sformatf("to.idle%0d.err", i), 32'(err_timeout), (i == 8) ? 32'h1 : 32'h0);
        chk($sformatf("to.idle%0d.cnt", i), 32'(byte_cnt), (i == 8) ? 32'h0 : 32'h1);
      end
      drive(1'b0, 8'h00, 1'b0);
      if (err_timeout) pulses++;
      chk("to.pulses", 32'(pulses), 32'h1);
      drive(1'b1, 8'h4C, 1'b0);
      drive(1'b1, 8'h6F, 1'b0);
      drive(1'b1, 8'h74, 1'b0);
      drive(1'b1, 8'h52, 1'b0);
      chk("to.after.key", key, 32'h4C6F7452);
      chk("to.after.kv", 32'(key_valid), 32'h1);
      chk("to.after.err", 32'(err_timeout), 32'h0);

      do_reset();
      drive(1'b1, 8'h4C, 1'b0);
      for (int i = 1; i <= 7; i++) begin
        drive(1'b0, 8'h00, 1'b0);
        chk($sformatf("race.idle%0d.err", i), 32'(err_timeout), 32'h0);
      end
      drive(1'b1, 8'h6F, 1'b0);
      chk("race.err", 32'(err_timeout), 32'h0);
      chk("race.cnt", 32'(byte_cnt), 32'h2);
      drive(1'b0, 8'h00, 1'b0);
      chk("race.next.err", 32'(err_timeout), 32'h0);
      chk("race.next.cnt", 32'(byte_cnt), 32'h2);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_byte_assembler.md
Name: key_byte_assembler

Overview:
- Upstream stage of the key-check top: collects a byte stream (e.g. from the UART receiver) and assembles it into the 32-bit key word the checker consumes.
- Bytes are packed big-endian: the first byte received lands in key[31:24].
- The completed key is presented with a valid/ack handshake. The key output holds stable between completions, so the checker can sample it on any clk edge.

Parameters:
- TIMEOUT_CYC, 1000, idle cycles allowed between bytes of one key before the partial key is discarded (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_byte  input  8  incoming key byte
- in_valid  input  1  in_byte is valid this cycle
- in_ready  output  1  block accepts a byte this cycle; a transfer occurs when in_valid && in_ready
- key  output  32  last completed key, registered
- key_valid  output  1  key holds a new, unacknowledged value
- key_ack  input  1  consumer has taken key
- byte_cnt  output  2  bytes of the current partial key collected (0..3)
- err_timeout  output  1  one-cycle pulse when a partial key is discarded

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. Asserting it clears all state immediately, independent of clk.
- Reset values:
  - key = 32'h00000000, key_valid = 0, byte_cnt = 0, err_timeout = 0
  - in_ready = 1; the FSM enters COLLECT.
- Internal storage: 24-bit shift register acc holds the first three bytes. key is written only on completion.
- FSM states: COLLECT, HOLD.
- COLLECT:
  - in_ready = 1.
  - On a transfer with byte_cnt < 3: acc = {acc[15:0], in_byte} and byte_cnt increments.
  - On a transfer with byte_cnt == 3:
    - key <= {acc, in_byte}, key_valid <= 1, byte_cnt <= 0, acc cleared.
    - Next state is HOLD.
  - Latency: key and key_valid change on the same edge that accepts the 4th byte, and are visible the following cycle.
- HOLD:
  - in_ready = 0; in_valid is ignored and no byte is lost, because the sender must hold it.
  - On key_ack = 1: key_valid <= 0 and the next state is COLLECT. key keeps its value.
- in_ready is a combinational decode of the registered state only. It does not depend on key_ack in the same cycle, so a byte is never accepted in the cycle key_ack is seen.
- key_ack while key_valid = 0 has no effect.
- key_valid never asserts without a preceding 4th-byte transfer. Back-to-back keys therefore cost at least 4 transfer cycles plus 1 ack cycle.
- Reset mid-key discards the partial bytes. Reset during HOLD clears key and key_valid.
- Without the optional feature, a partial key waits indefinitely and err_timeout is tied 0.

Optional Feature:
- Macro: KEY_BYTE_ASSEMBLER_TIMEOUT_EN.
- Defined:
  - An idle counter (clog2(TIMEOUT_CYC)+1 bits) runs in COLLECT while byte_cnt != 0. It resets to 0 on every transfer.
  - When it reaches TIMEOUT_CYC-1 with no transfer that cycle: acc and byte_cnt clear, and err_timeout pulses high for exactly one cycle.
  - key and key_valid are unaffected.
  - A transfer arriving in the expiry cycle wins: the byte is accepted, there is no timeout, and the counter restarts.
  - The counter is held at 0 in HOLD and when byte_cnt == 0.
- Undefined: no counter logic; err_timeout is driven constant 0.

Test Plan:
- Reset, then send 'L','o','t','R' (0x4C,0x6F,0x74,0x52) back-to-back -> byte_cnt steps 1,2,3,0; key = 32'h4C6F7452 and key_valid = 1 the cycle after the 4th byte; in_ready = 0.
- Hold in_valid with 0x4C for 3 cycles while in HOLD, then pulse key_ack -> no acceptance during HOLD; key_valid drops; the byte is accepted on the first COLLECT cycle; key still reads 32'h4C6F7452.
- Send 0x4C,0x6F,0x74,0x53 after acking the previous key -> key = 32'h4C6F7453 and the old value is visible until the completing edge.
- Send 2 bytes, assert rst_n = 0 asynchronously mid-cycle -> key = 0, key_valid = 0, byte_cnt = 0 immediately; the next 4 bytes 0x00 produce key = 32'h00000000 with key_valid = 1.
- With KEY_BYTE_ASSEMBLER_TIMEOUT_EN and TIMEOUT_CYC = 8: send 0x4C, idle 8 cycles -> err_timeout pulses once and byte_cnt = 0; then send 4 bytes 0x4C,0x6F,0x74,0x52 -> key = 32'h4C6F7452.
- With the feature enabled: send 0x4C, idle 7 cycles, send 0x6F on the expiry cycle -> no err_timeout and byte_cnt = 2.
